gfq_systemizer: RTL and testbench

- Parametrised successor to the fixed GF(3) systemizer. Brings an L x K matrix over GF(Q), for any prime Q, to systematic form [I | A] by element-serial Gauss-Jordan elimination with pivot search and row swap.
- Matrix is held internally. It is loaded and read back through a BLOCK-element word port.
- Sits behind the top-level wrapper. start/done/success/fail map to IO pins.

---
 rtl/gfq_systemizer_if.sv | 36 +++
 rtl/gfq_systemizer.sv | 211 +++++++++++++++++++++
 tb/tb_gfq_systemizer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gfq_systemizer_if.sv
// Host-side bus of the GF(Q) systemizer: run control, status and the
// word-wide matrix load/readback port. Widths follow the matrix geometry.
interface gfq_systemizer_if #(
  parameter int L     = 8,
  parameter int K     = 16,
  parameter int Q     = 3,
  parameter int BLOCK = 4
);
  localparam int EW  = $clog2(Q);
  localparam int WPR = K / BLOCK;
  localparam int AW  = $clog2(L * WPR);
  localparam int DW  = BLOCK * EW;

  logic          start;
  logic          busy;
  logic          done;
  logic          success;
  logic          fail;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          acc_err;

  modport master (
    output start, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  busy, done, success, fail, rd_data, acc_err
  );

  modport slave (
    input  start, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output busy, done, success, fail, rd_data, acc_err
  );
endinterface

// File: rtl/gfq_systemizer.sv
// gfq_systemizer: brings an L x K matrix over GF(Q) to [I | A] by
// element-serial Gauss-Jordan elimination (pivot search, row swap,
// inverse by trial, normalise, eliminate). Matrix lives in flops and is
// loaded/read back through a BLOCK-element word port while idle.
module gfq_systemizer #(
  parameter int L     = 8,
  parameter int K     = 16,
  parameter int Q     = 3,
  parameter int BLOCK = 4
) (
  input logic             clk,
  input logic             rst_n,
  gfq_systemizer_if.slave bus
);
  localparam int EW  = $clog2(Q);
  localparam int WPR = K / BLOCK;
  localparam int NW  = L * WPR;
  localparam int DW  = BLOCK * EW;
  localparam int RW  = (L > 1) ? $clog2(L) : 1;
  localparam int CW  = (K > 1) ? $clog2(K) : 1;
  localparam int PW  = 2 * EW;
  localparam logic [PW-1:0] QP       = PW'(Q);
  localparam logic [RW-1:0] LAST_ROW = RW'(L - 1);
  localparam logic [CW-1:0] LAST_K   = CW'(K - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEARCH, S_SWAP, S_INV, S_NORM, S_ELIM, S_FINISH
  } state_t;

  function automatic logic [EW-1:0] mod_q(input logic [PW-1:0] v);
    return EW'(v % QP);
  endfunction

  // Operands are < Q, so the double-width product cannot overflow.
  function automatic logic [EW-1:0] mul_q(input logic [EW-1:0] a, input logic [EW-1:0] b);
    return mod_q(PW'(a) * PW'(b));
  endfunction

  logic [EW-1:0] mem [L][K];
  state_t        state, state_nxt;
  logic [RW-1:0] col, row, piv, elim0;
  logic [CW-1:0] k, col_k;
  logic [EW-1:0] x, f_q, elim_f, norm_val, elim_val;
  logic          busy_w, start_go, set_ok, set_fail;
  logic          srch_nz, inv_hit, row_end, last_row;
  logic          success_q, fail_q, acc_err_q;
  logic          wr_ok, rd_ok;
  logic [RW-1:0] wr_row, rd_row;
  logic [CW-1:0] wr_col0, rd_col0;
  logic [DW-1:0] rd_data_q, rd_word;
  int            nr;

  assign busy_w   = (state != S_IDLE) && (state != S_FINISH);
  assign start_go = (state == S_IDLE) && bus.start;

  // Host word address -> row and first column; out-of-range words are inert.
  assign wr_ok   = int'(bus.wr_addr) < NW;
  assign wr_row  = RW'(int'(bus.wr_addr) / WPR);
  assign wr_col0 = CW'((int'(bus.wr_addr) % WPR) * BLOCK);
  assign rd_ok   = int'(bus.rd_addr) < NW;
  assign rd_row  = RW'(int'(bus.rd_addr) / WPR);
  assign rd_col0 = CW'((int'(bus.rd_addr) % WPR) * BLOCK);

  // Element-serial datapath terms for the current (row, col, k).
  assign col_k    = CW'(col);
  assign elim0    = (col == '0) ? RW'(1) : '0;
  assign srch_nz  = mem[row][col_k] != '0;
  assign inv_hit  = mul_q(mem[col][col_k], x) == EW'(1);
  assign elim_f   = (k == '0) ? mem[row][col_k] : f_q;
  assign norm_val = mul_q(mem[col][k], x);
  assign elim_val = mod_q(PW'(mem[row][k]) + QP - PW'(mul_q(elim_f, mem[col][k])));
  assign row_end  = (elim_f == '0) || (k == LAST_K);

  // Next row to eliminate, stepping over the pivot row.
  // NOTE: combinational blocks use blocking '=' so later lines see earlier
  // results; clocked blocks use '<=' so every flop samples pre-edge values.
  always_comb begin
    nr = int'(row) + 1;
    if (nr == int'(col)) nr = nr + 1;
    last_row = nr >= L;
  end

  // Gather one host word for readback.
  always_comb begin
    rd_word = '0;
    if (rd_ok)
      for (int j = 0; j < BLOCK; j++)
        rd_word[j*EW +: EW] = mem[rd_row][rd_col0 + CW'(j)];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state and status-set strobes.
  // NOTE: every output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    set_ok    = 1'b0;
    set_fail  = 1'b0;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_SEARCH;
      S_SEARCH: begin
        if (srch_nz) state_nxt = (row == col) ? S_INV : S_SWAP;
        else if (row == LAST_ROW) begin
          state_nxt = S_FINISH;
          set_fail  = 1'b1;
        end
      end
      S_SWAP:   if (k == LAST_K) state_nxt = S_INV;
      S_INV:    if (inv_hit) state_nxt = (x == EW'(1)) ? S_ELIM : S_NORM;
      S_NORM:   if (k == LAST_K) state_nxt = S_ELIM;
      S_ELIM: begin
        if (row_end && last_row) begin
          if (col == LAST_ROW) begin
            state_nxt = S_FINISH;
            set_ok    = 1'b1;
          end else begin
            state_nxt = S_SEARCH;
          end
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Matrix, loop counters, host port and sticky status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the matrix is a flop array, not a RAM macro, so it is cleared
      // by reset; readback of zeros after reset depends on it.
      for (int r = 0; r < L; r++)
        for (int c = 0; c < K; c++)
          mem[r][c] <= '0;
      col <= '0; row <= '0; piv <= '0; k <= '0;
      x <= '0; f_q <= '0;
      rd_data_q <= '0; acc_err_q <= 1'b0;
      success_q <= 1'b0; fail_q <= 1'b0;
    end else begin
      acc_err_q <= busy_w && (bus.wr_en || bus.rd_en);
      if (!busy_w) begin
        if (bus.wr_en && wr_ok)
          for (int j = 0; j < BLOCK; j++)
            mem[wr_row][wr_col0 + CW'(j)] <= mod_q(PW'(bus.wr_data[j*EW +: EW]));
        if (bus.rd_en) rd_data_q <= rd_word;
      end
      if (start_go) begin
        success_q <= 1'b0;
        fail_q    <= 1'b0;
        col <= '0; row <= '0; k <= '0;
      end
      if (set_ok)   success_q <= 1'b1;
      if (set_fail) fail_q    <= 1'b1;
      case (state)
        S_SEARCH: begin
          if (srch_nz) begin
            piv <= row;
            k   <= '0;
            x   <= EW'(1);
          end else begin
            row <= row + RW'(1);
          end
        end
        S_SWAP: begin
          mem[piv][k] <= mem[col][k];
          mem[col][k] <= mem[piv][k];
          k <= (k == LAST_K) ? '0 : k + CW'(1);
        end
        S_INV: begin
          if (inv_hit) begin
            k   <= '0;
            row <= elim0;
          end else begin
            x <= x + EW'(1);
          end
        end
        S_NORM: begin
          mem[col][k] <= norm_val;
          k <= (k == LAST_K) ? '0 : k + CW'(1);
        end
        S_ELIM: begin
          if (k == '0) f_q <= mem[row][col_k];
          if (elim_f != '0) mem[row][k] <= elim_val;
          if (row_end) begin
            k <= '0;
            if (last_row) begin
              col <= col + RW'(1);
              row <= col + RW'(1);
            end else begin
              row <= RW'(nr);
            end
          end else begin
            k <= k + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_w;
  assign bus.done    = (state == S_FINISH);
  assign bus.success = success_q;
  assign bus.fail    = fail_q;
  assign bus.rd_data = rd_data_q;
  assign bus.acc_err = acc_err_q;
endmodule

// File: tb/tb_gfq_systemizer.sv
// Bench for gfq_systemizer: two instances (GF(3) 8x16, GF(5) 4x8) driven by
// directed steps with random matrices, checked against a plain Gauss-Jordan
// reference model.
module tb_gfq_systemizer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gfq_systemizer_if #(.L(8), .K(16), .Q(3), .BLOCK(4)) ia ();
  gfq_systemizer_if #(.L(4), .K(8),  .Q(5), .BLOCK(2)) ib ();

  gfq_systemizer #(.L(8), .K(16), .Q(3), .BLOCK(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  gfq_systemizer #(.L(4), .K(8),  .Q(5), .BLOCK(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  int cfg_l  [2] = '{8, 4};
  int cfg_k  [2] = '{16, 8};
  int cfg_q  [2] = '{3, 5};
  int cfg_b  [2] = '{4, 2};
  int cfg_ew [2] = '{2, 3};

  int errors = 0;
  int checks = 0;
  int init_m [8][16];
  int g      [8][16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_host(input int d, input logic st, input logic we, input int wa,
                          input logic [31:0] wd, input logic re, input int ra);
    if (d == 0) begin
      ia.start = st; ia.wr_en = we; ia.wr_addr = 5'(wa); ia.wr_data = 8'(wd);
      ia.rd_en = re; ia.rd_addr = 5'(ra);
    end else begin
      ib.start = st; ib.wr_en = we; ib.wr_addr = 4'(wa); ib.wr_data = 6'(wd);
      ib.rd_en = re; ib.rd_addr = 4'(ra);
    end
  endtask

  task automatic idle(input int d);
    set_host(d, 1'b0, 1'b0, 0, 32'h0, 1'b0, 0);
  endtask

  function automatic logic get_busy(input int d); return (d != 0) ? ib.busy    : ia.busy;    endfunction
  function automatic logic get_done(input int d); return (d != 0) ? ib.done    : ia.done;    endfunction
  function automatic logic get_succ(input int d); return (d != 0) ? ib.success : ia.success; endfunction
  function automatic logic get_fail(input int d); return (d != 0) ? ib.fail    : ia.fail;    endfunction
  function automatic logic get_acc (input int d); return (d != 0) ? ib.acc_err : ia.acc_err; endfunction
  function automatic logic [31:0] get_rd(input int d);
    return (d != 0) ? 32'(ib.rd_data) : 32'(ia.rd_data);
  endfunction

  function automatic int num_words(input int d);
    return cfg_l[d] * (cfg_k[d] / cfg_b[d]);
  endfunction

  // Pack one host word from the loaded matrix (src=0) or the model (src=1).
  function automatic logic [31:0] pack(input int d, input int src, input int a);
    int wpr, r, c0;
    logic [31:0] w;
    wpr = cfg_k[d] / cfg_b[d];
    r   = a / wpr;
    c0  = (a % wpr) * cfg_b[d];
    w   = '0;
    for (int j = 0; j < cfg_b[d]; j++)
      w = w | (32'(src != 0 ? g[r][c0 + j] : init_m[r][c0 + j]) << (j * cfg_ew[d]));
    return w;
  endfunction

  // Reference Gauss-Jordan on g. Returns -1 on full rank, else the column
  // with no pivot (g is left as it stood at that point).
  function automatic int model_run(input int d);
    int l, kk, q, p, inv, f, t;
    l = cfg_l[d]; kk = cfg_k[d]; q = cfg_q[d];
    for (int c = 0; c < l; c++) begin
      p = -1;
      for (int r = c; r < l; r++)
        if (p < 0 && g[r][c] != 0) p = r;
      if (p < 0) return c;
      for (int j = 0; j < kk; j++) begin
        t = g[p][j]; g[p][j] = g[c][j]; g[c][j] = t;
      end
      inv = 0;
      for (int v = 1; v < q; v++)
        if ((g[c][c] * v) % q == 1) inv = v;
      for (int j = 0; j < kk; j++) g[c][j] = (g[c][j] * inv) % q;
      for (int r = 0; r < l; r++) begin
        if (r != c) begin
          f = g[r][c];
          for (int j = 0; j < kk; j++)
            g[r][j] = (((g[r][j] - f * g[c][j]) % q) + q) % q;
        end
      end
    end
    return -1;
  endfunction

  task automatic rand_fill(input int d);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++)
        init_m[r][c] = (r < cfg_l[d] && c < cfg_k[d]) ? int'($urandom_range(cfg_q[d] - 1, 0)) : 0;
  endtask

  task automatic write_word(input int d, input int a, input logic [31:0] w);
    set_host(d, 1'b0, 1'b1, a, w, 1'b0, 0);
    step();
    idle(d);
  endtask

  task automatic read_word(input int d, input int a, output logic [31:0] w);
    set_host(d, 1'b0, 1'b0, 0, 32'h0, 1'b1, a);
    step();
    w = get_rd(d);
    idle(d);
  endtask

  task automatic load(input int d);
    for (int a = 0; a < num_words(d); a++) write_word(d, a, pack(d, 0, a));
  endtask

  task automatic verify(input int d, input string tag);
    logic [31:0] w;
    for (int a = 0; a < num_words(d); a++) begin
      read_word(d, a, w);
      check($sformatf("%s word%0d", tag, a), w, pack(d, 1, a));
    end
  endtask

  task automatic start_run(input int d, input string tag);
    set_host(d, 1'b1, 1'b0, 0, 32'h0, 1'b0, 0);
    step();
    idle(d);
    check({tag, " busy after start"}, 32'(get_busy(d)), 32'd1);
  endtask

  task automatic wait_done(input int d, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      if (get_done(d)) seen = 1'b1;
      else step();
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, " busy low at done"}, 32'(get_busy(d)), 32'd0);
      step();
      check({tag, " done one cycle"}, 32'(get_done(d)), 32'd0);
    end
  endtask

  task automatic check_status(input int d, input string tag, input int res);
    check({tag, " success"}, 32'(get_succ(d)), 32'(res < 0));
    check({tag, " fail"},    32'(get_fail(d)), 32'(res >= 0));
  endtask

  initial begin
    logic [31:0] w, prev;
    int res, tries;
    idle(0);
    idle(1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Reset state of both instances.
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst busy%0d", d),    32'(get_busy(d)), 32'd0);
      check($sformatf("rst done%0d", d),    32'(get_done(d)), 32'd0);
      check($sformatf("rst success%0d", d), 32'(get_succ(d)), 32'd0);
      check($sformatf("rst fail%0d", d),    32'(get_fail(d)), 32'd0);
      check($sformatf("rst acc_err%0d", d), 32'(get_acc(d)),  32'd0);
      check($sformatf("rst rd_data%0d", d), get_rd(d),        32'd0);
    end
    read_word(0, 7, w);
    check("rst read a", w, 32'd0);
    read_word(1, 3, w);
    check("rst read b", w, 32'd0);

    // Already systematic: identity left block, 0..2 pattern on the right.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++)
        init_m[r][c] = (c < 8) ? int'(r == c) : (r + c) % 3;
    g = init_m;
    load(0);
    start_run(0, "ident");
    wait_done(0, "ident");
    check_status(0, "ident", -1);
    verify(0, "ident");

    // Pivot for column 0 found in row 2 (value 2): swap plus scale by 2.
    tries = 0;
    do begin
      rand_fill(0);
      init_m[0][0] = 0; init_m[1][0] = 0; init_m[2][0] = 2;
      g = init_m;
      res = model_run(0);
      tries++;
    end while (res != -1 && tries < 50);
    load(0);
    start_run(0, "swap");
    wait_done(0, "swap");
    check_status(0, "swap", res);
    verify(0, "swap");

    // Column 3 zero everywhere: rank deficient, fails at column 3.
    tries = 0;
    do begin
      rand_fill(0);
      for (int r = 0; r < 8; r++) init_m[r][3] = 0;
      g = init_m;
      res = model_run(0);
      tries++;
    end while (res != 3 && tries < 50);
    load(0);
    start_run(0, "rankfail");
    wait_done(0, "rankfail");
    check_status(0, "rankfail", res);
    verify(0, "rankfail");

    // GF(5): out-of-field element reduced on write (7 -> 2).
    write_word(1, 0, 32'd15);
    read_word(1, 0, w);
    check("gf5 write reduce", w, 32'd10);

    // GF(5): M[0][0]=2 needs inverse 3.
    tries = 0;
    do begin
      rand_fill(1);
      init_m[0][0] = 2;
      g = init_m;
      res = model_run(1);
      tries++;
    end while (res != -1 && tries < 50);
    load(1);
    start_run(1, "gf5");
    wait_done(1, "gf5");
    check_status(1, "gf5", res);
    verify(1, "gf5");

    // Host accesses and a second start while busy.
    tries = 0;
    do begin
      rand_fill(0);
      g = init_m;
      res = model_run(0);
      tries++;
    end while (res != -1 && tries < 50);
    load(0);
    read_word(0, 5, prev);
    start_run(0, "busyacc");
    set_host(0, 1'b0, 1'b1, 0, 32'hFFFF_FFFF, 1'b0, 0);
    step();
    check("busyacc acc_err wr", 32'(get_acc(0)), 32'd1);
    set_host(0, 1'b0, 1'b0, 0, 32'h0, 1'b1, 1);
    step();
    check("busyacc acc_err rd", 32'(get_acc(0)), 32'd1);
    check("busyacc rd_data held", get_rd(0), prev);
    set_host(0, 1'b1, 1'b0, 0, 32'h0, 1'b0, 0);
    step();
    idle(0);
    check("busyacc acc_err start", 32'(get_acc(0)), 32'd0);
    check("busyacc still busy", 32'(get_busy(0)), 32'd1);
    wait_done(0, "busyacc");
    check_status(0, "busyacc", res);
    verify(0, "busyacc");

    // Reset in the middle of column-0 elimination.
    rand_fill(0);
    init_m[0][0] = 1;
    load(0);
    start_run(0, "midrst");
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst busy",    32'(get_busy(0)), 32'd0);
    check("midrst done",    32'(get_done(0)), 32'd0);
    check("midrst success", 32'(get_succ(0)), 32'd0);
    check("midrst fail",    32'(get_fail(0)), 32'd0);
    check("midrst rd_data", get_rd(0),        32'd0);
    step();
    check("midrst no done", 32'(get_done(0)), 32'd0);
    for (int a = 0; a < num_words(0); a++) begin
      read_word(0, a, w);
      check($sformatf("midrst zero word%0d", a), w, 32'd0);
    end
    g = init_m;
    res = model_run(0);
    load(0);
    start_run(0, "rerun");
    wait_done(0, "rerun");
    check_status(0, "rerun", res);
    verify(0, "rerun");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
